// File: rtl/aes_round_ctrl_pkg.sv
// aes_pkg: shared constants, FSM encoding and byte-level helpers for the AES round controller
package aes_pkg;
  localparam int NR_DEF = 10;
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} fsm_t;
  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [127:0] shiftrows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*byte_idx(r, c) -: 8] = s[127-8*byte_idx(r, (c + r) % 4) -: 8];
    return o;
  endfunction
endpackage

// File: rtl/aes_round_ctrl_mixcolumns.sv
// aes_round_ctrl_mixcolumns: combinational AES MixColumns over four column-major columns
module aes_round_ctrl_mixcolumns
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = din[127-32*c -: 32];
    assign dout[127-32*c -: 32] = {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  end
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 round sequencer; AES_ROUND_CTRL_ABORT_EN adds an abort input
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic [127:0] sb_in,
  input  logic [127:0] sb_out,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic         abort,
`endif
  output logic [127:0] ciphertext,
  output logic         busy
);
  fsm_t fsm, fsm_n;
  logic [127:0] st, st_n, sr, mc;
  logic [3:0] round, round_n;
  logic abort_hit;
`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif
  assign sr = shiftrows(sb_out);
  aes_round_ctrl_mixcolumns u_mc (.din(sr), .dout(mc));
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm   <= IDLE;
      st    <= '0;
      round <= '0;
    end else begin
      fsm   <= fsm_n;
      st    <= st_n;
      round <= round_n;
    end
  end
  always_comb begin
    fsm_n   = fsm;
    st_n    = st;
    round_n = round;
    case (fsm)
      IDLE: if (in_valid && !abort_hit) begin
        st_n    = plaintext ^ rk;
        round_n = 4'd1;
        fsm_n   = ROUND;
      end
      ROUND: begin
        st_n    = (round < 4'(NR)) ? mc ^ rk : sr ^ rk;
        round_n = (round < 4'(NR)) ? round + 4'd1 : round;
        fsm_n   = (round < 4'(NR)) ? ROUND : DONE;
      end
      DONE: if (out_ready) begin
        fsm_n   = IDLE;
        round_n = '0;
      end
      default: fsm_n = IDLE;
    endcase
    // abort overrides everything outside IDLE and throws the block away
    if (abort_hit && fsm != IDLE) begin
      fsm_n   = IDLE;
      st_n    = '0;
      round_n = '0;
    end
  end
  assign in_ready   = fsm == IDLE;
  assign busy       = fsm != IDLE;
  assign out_valid  = fsm == DONE;
  assign rk_idx     = (fsm == ROUND) ? round : 4'd0;
  assign sb_in      = st;
  assign ciphertext = st;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed FIPS-197 vectors with S-box and key-schedule models driving the controller
module tb_aes_round_ctrl;
  localparam int NR = 10;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [127:0] plaintext = '0, rk, sb_in, sb_out, ciphertext;
  logic [3:0] rk_idx;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic abort = 0;
`endif
  logic [7:0] sb_tab [256];
  logic [127:0] rks [11];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .rk_idx(rk_idx), .rk(rk), .sb_in(sb_in),
    .sb_out(sb_out), .out_valid(out_valid), .out_ready(out_ready),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .ciphertext(ciphertext), .busy(busy)
  );

  always_comb begin
    sb_out = '0;
    for (int k = 0; k < 16; k++) sb_out[127-8*k -: 8] = sb_tab[sb_in[127-8*k -: 8]];
  end
  always_comb rk = (int'(rk_idx) <= NR) ? rks[rk_idx] : '0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] p = (x == 0) ? 8'h00 : 8'h01;
    if (x != 0) for (int i = 0; i < 254; i++) p = gmul(p, x);
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb_tab[w[31:24]], sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0] rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      if (i % 4 == 0) begin
        w[i] = w[i-4] ^ subword({w[i-1][23:0], w[i-1][31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else w[i] = w[i-4] ^ w[i-1];
    end
    for (int r = 0; r <= NR; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] m_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sb_tab[s[127-8*k -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] m_shift(input logic [127:0] s);
    logic [7:0] b [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = b[(k + 4 * (k % 4)) % 16];
    return o;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3, a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3,
                           a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3), gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2)};
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [127:0] p, input logic [127:0] key);
    expand(key);
    plaintext = p;
    in_valid = 1;
    chk("idle_in_ready", 128'(in_ready), 1);
    chk("idle_rk_idx", 128'(rk_idx), 0);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic run_block(input logic [127:0] p, input logic [127:0] key, input logic [127:0] exp, input bit hold);
    logic [127:0] s;
    int cyc = 0;
    accept(p, key);
    s = p ^ rks[0];
    for (int r = 1; r < NR; r++) s = m_mix(m_shift(m_sub(s))) ^ rks[r];
    while (!out_valid && cyc < 20) begin
      chk("rk_idx_trace", 128'(rk_idx), 128'(cyc + 1));
      if (cyc == NR - 1) chk("round9_state", ciphertext, s);
      @(negedge clk);
      cyc++;
    end
    chk("latency", 128'(cyc), NR);
    chk("ciphertext", ciphertext, exp);
    if (hold) for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      @(negedge clk);
      chk("hold_out_valid", 128'(out_valid), 1);
      chk("hold_ciphertext", ciphertext, exp);
      chk("hold_in_ready", 128'(in_ready), 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("release_out_valid", 128'(out_valid), 0);
    chk("release_in_ready", 128'(in_ready), 1);
    chk("release_busy", 128'(busy), 0);
  endtask

  typedef struct {
    logic [127:0] p, key, exp;
    bit hold;
  } vec_t;
  vec_t vecs [3];

  initial begin
    for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));
    vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32, 1'b0};
    vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1};
    vecs[2] = vecs[0];
    expand(vecs[0].key);
    repeat (2) @(negedge clk);
    chk("reset_ciphertext", ciphertext, 0);
    chk("reset_out_valid", 128'(out_valid), 0);
    chk("reset_busy", 128'(busy), 0);
    chk("reset_in_ready", 128'(in_ready), 1);
    rst = 0;
    for (int i = 0; i < 3; i++) run_block(vecs[i].p, vecs[i].key, vecs[i].exp, vecs[i].hold);
    accept(vecs[0].p, vecs[0].key);
    repeat (3) @(negedge clk);
    chk("pre_rst_rk_idx", 128'(rk_idx), 4);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_out_valid", 128'(out_valid), 0);
    chk("rst_mid_ciphertext", ciphertext, 0);
    chk("rst_mid_in_ready", 128'(in_ready), 1);
    chk("rst_mid_rk_idx", 128'(rk_idx), 0);
    run_block(vecs[0].p, vecs[0].key, vecs[0].exp, 1'b0);
`ifdef AES_ROUND_CTRL_ABORT_EN
    accept(vecs[0].p, vecs[0].key);
    repeat (5) @(negedge clk);
    chk("pre_abort_rk_idx", 128'(rk_idx), 6);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_in_ready", 128'(in_ready), 1);
    chk("abort_ciphertext", ciphertext, 0);
    chk("abort_busy", 128'(busy), 0);
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_out_valid", 128'(out_valid), 0);
    end
    abort = 1;
    in_valid = 1;
    @(negedge clk);
    abort = 0;
    in_valid = 0;
    chk("abort_idle_busy", 128'(busy), 0);
    chk("abort_idle_in_ready", 128'(in_ready), 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
